// File: rtl/pwm_capture.sv
// pwm_capture: per-channel PWM high-time/period capture on a synchronized pwmclock tick; ports: clk, rst, ce/addr/sel read strobe and select, pwmclock sample clock, in[N] PWM inputs, data/valid registered read result
module pwm_capture #(
  parameter int Resolution   = 8,
  parameter int AddressWidth = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         ce,
  input  logic [AddressWidth-1:0]      addr,
  input  logic                         sel,
  input  logic                         pwmclock,
  input  logic [2**AddressWidth-1:0]   in,
  output logic [Resolution-1:0]        data,
  output logic                         valid
);
  localparam int N = 2**AddressWidth;
  localparam logic [Resolution-1:0] MAX = '1;
  logic [2:0] pclk_q, pclk_d;
  logic [N-1:0] meta_q, meta_d, s_q, s_d, prev_q, prev_d, armed_q, armed_d, vld_q, vld_d;
  logic [N-1:0][Resolution-1:0] pcnt_q, pcnt_d, hcnt_q, hcnt_d, per_q, per_d, duty_q, duty_d;
  logic [Resolution-1:0] data_q, data_d;
  logic valid_q, valid_d, tick;
  assign tick = pclk_q[1] & ~pclk_q[2];
  assign data = data_q;
  assign valid = valid_q;
  always_comb begin
    pclk_d  = {pclk_q[1:0], pwmclock};
    meta_d  = in;
    s_d     = meta_q;
    prev_d  = tick ? s_q : prev_q;
    armed_d = armed_q;
    vld_d   = vld_q;
    pcnt_d  = pcnt_q;
    hcnt_d  = hcnt_q;
    per_d   = per_q;
    duty_d  = duty_q;
    for (int i = 0; i < N; i++) begin
      if (tick && s_q[i] && !prev_q[i]) begin
        per_d[i]   = armed_q[i] ? pcnt_q[i] : per_q[i];
        duty_d[i]  = armed_q[i] ? hcnt_q[i] : duty_q[i];
        vld_d[i]   = vld_q[i] | armed_q[i];
        armed_d[i] = 1'b1;
        pcnt_d[i]  = Resolution'(1);
        hcnt_d[i]  = Resolution'(1);
      end else if (tick && armed_q[i] && pcnt_q[i] == MAX) begin
        per_d[i]  = MAX;
        duty_d[i] = hcnt_q[i];
        vld_d[i]  = 1'b1;
        pcnt_d[i] = '0;
        hcnt_d[i] = '0;
      end else if (tick && armed_q[i]) begin
        pcnt_d[i] = pcnt_q[i] + Resolution'(1);
        hcnt_d[i] = hcnt_q[i] + Resolution'(s_q[i]);
      end
    end
    data_d  = ce ? (sel ? per_q[addr] : duty_q[addr]) : data_q;
    valid_d = ce ? vld_q[addr] : valid_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pclk_q  <= '0;
      meta_q  <= '0;
      s_q     <= '0;
      prev_q  <= '0;
      armed_q <= '0;
      vld_q   <= '0;
      pcnt_q  <= '0;
      hcnt_q  <= '0;
      per_q   <= '0;
      duty_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      pclk_q  <= pclk_d;
      meta_q  <= meta_d;
      s_q     <= s_d;
      prev_q  <= prev_d;
      armed_q <= armed_d;
      vld_q   <= vld_d;
      pcnt_q  <= pcnt_d;
      hcnt_q  <= hcnt_d;
      per_q   <= per_d;
      duty_q  <= duty_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end
endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: randomized and directed stimulus checked every cycle against a queue-based capture model
module tb_pwm_capture;
  localparam int R = 8, AW = 2, N = 4, MAX = 255;
  logic clk = 0, rst = 1, ce = 0, sel = 0, pwmclock = 0;
  logic [AW-1:0] addr = '0;
  logic [N-1:0] in_v = '0;
  logic [R-1:0] data;
  logic valid;
  int errors = 0, checks = 0;
  bit mprev[N], marmed[N], mvld[N];
  int mper[N], mduty[N];
  bit seg[N][$];
  int pend_cnt = 0;
  logic [N-1:0] pend_val = '0;
  logic [R-1:0] exp_data = '0;
  logic exp_valid = 0;
  bit chk_en = 0;
  pwm_capture #(.Resolution(R), .AddressWidth(AW)) dut (
    .clk(clk), .rst(rst), .ce(ce), .addr(addr), .sel(sel),
    .pwmclock(pwmclock), .in(in_v), .data(data), .valid(valid)
  );
  always #5 clk = ~clk;
  task automatic model_tick(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) begin
      int ones;
      ones = 0;
      for (int k = 0; k < seg[i].size(); k++) ones += int'(seg[i][k]);
      if (v[i] && !mprev[i]) begin
        if (marmed[i]) begin
          mper[i] = seg[i].size();
          mduty[i] = ones;
          mvld[i] = 1;
        end
        marmed[i] = 1;
        seg[i].delete();
        seg[i].push_back(1'b1);
      end else if (marmed[i] && seg[i].size() == MAX) begin
        mper[i] = MAX;
        mduty[i] = ones;
        mvld[i] = 1;
        seg[i].delete();
      end else if (marmed[i]) begin
        seg[i].push_back(v[i]);
      end
      mprev[i] = v[i];
    end
  endtask
  initial begin : model
    forever begin
      @(posedge clk);
      if (rst) begin
        exp_data = '0;
        exp_valid = 0;
        pend_cnt = 0;
        for (int i = 0; i < N; i++) begin
          mprev[i] = 0; marmed[i] = 0; mvld[i] = 0; mper[i] = 0; mduty[i] = 0;
          seg[i].delete();
        end
      end else begin
        if (ce) begin
          exp_data = sel ? R'(mper[addr]) : R'(mduty[addr]);
          exp_valid = mvld[addr];
        end
        if (pend_cnt > 0) begin
          pend_cnt--;
          if (pend_cnt == 0) model_tick(pend_val);
        end
      end
    end
  end
  initial begin : compare
    forever begin
      @(negedge clk);
      if (chk_en) begin
        checks++;
        if (data !== exp_data || valid !== exp_valid) begin
          errors++;
          $display("FAIL cycle_read t=%0t: data=%0d valid=%0b, expected data=%0d valid=%0b",
                   $time, data, valid, exp_data, exp_valid);
        end
      end
    end
  end
  task automatic tick(input logic [N-1:0] v, input int h, input int l, input bit do_rst);
    for (int c = 0; c < h + l; c++) begin
      @(negedge clk);
      pwmclock = (c < h);
      if (c == 0) begin
        in_v = v;
        pend_val = v;
        pend_cnt = 3;
      end
      rst = do_rst && (c == h + l - 1);
      ce = 1'($urandom_range(0, 1));
      addr = AW'($urandom_range(0, N - 1));
      sel = 1'($urandom_range(0, 1));
    end
  endtask
  task automatic rd(input int a, input bit s, input int ed, input bit ev, input string nm);
    @(negedge clk);
    rst = 0; pwmclock = 0; ce = 1; addr = AW'(a); sel = s;
    @(negedge clk);
    ce = 0; addr = AW'($urandom_range(0, N - 1)); sel = 1'($urandom_range(0, 1));
    checks++;
    if (data !== R'(ed) || valid !== ev) begin
      errors++;
      $display("FAIL %s: data=%0d valid=%0b, expected data=%0d valid=%0b", nm, data, valid, ed, ev);
    end
    @(negedge clk);
    checks++;
    if (data !== R'(ed) || valid !== ev) begin
      errors++;
      $display("FAIL %s_hold: data=%0d valid=%0b, expected data=%0d valid=%0b", nm, data, valid, ed, ev);
    end
  endtask
  initial begin : stim
    logic [N-1:0] v;
    int d[3];
    repeat (2) @(negedge clk);
    rst = 0;
    chk_en = 1;
    for (int a = 0; a < N; a++) begin
      rd(a, 0, 0, 0, "reset_duty");
      rd(a, 1, 0, 0, "reset_period");
    end
    for (int t = 0; t < 520; t++) begin
      v[0] = (t % 8) < 3;
      v[1] = (t == 0);
      v[2] = 1'b0;
      v[3] = 1'b1;
      tick(v, 4, 4, 0);
      if (t == 0) rd(0, 0, 0, 0, "ch0_armed_only");
      if (t == 7) rd(0, 1, 0, 0, "ch0_before_2nd_edge");
      if (t == 8) begin
        rd(0, 0, 3, 1, "ch0_duty");
        rd(0, 1, 8, 1, "ch0_period");
      end
      if (t == 255) begin
        rd(3, 0, 255, 1, "ch3_high_duty");
        rd(3, 1, 255, 1, "ch3_high_period");
        rd(1, 0, 1, 1, "ch1_first_timeout_duty");
      end
      if (t == 511) begin
        rd(1, 0, 0, 1, "ch1_low_duty");
        rd(1, 1, 255, 1, "ch1_low_period");
        rd(2, 0, 0, 0, "ch2_never_armed");
      end
    end
    d[0] = 8'h24; d[1] = 8'h81; d[2] = 8'h09;
    for (int t = 0; t < 410; t++) begin
      for (int i = 0; i < 3; i++) v[i] = (t % 200) < d[i];
      v[3] = 1'b1;
      tick(v, 3, 3, 0);
    end
    for (int i = 0; i < 3; i++) rd(i, 0, d[i], 1, "multi_duty");
    rd(0, 1, 200, 1, "multi_period");
    rd(3, 0, 255, 1, "multi_duty_ch3");
    for (int t = 0; t <= 24; t++) begin
      v = '0;
      v[0] = (t % 8) < 3;
      tick(v, 4, 4, t == 12);
      if (t == 12) rd(0, 1, 0, 0, "post_reset");
      if (t == 16) rd(0, 0, 0, 0, "rearm_only");
      if (t == 24) begin
        rd(0, 0, 3, 1, "post_reset_duty");
        rd(0, 1, 8, 1, "post_reset_period");
      end
    end
    for (int t = 0; t < 600; t++) begin
      for (int i = 0; i < N; i++) if ($urandom_range(0, 3) == 0) v[i] = ~v[i];
      tick(v, $urandom_range(2, 4), $urandom_range(2, 4), $urandom_range(0, 99) == 0);
    end
    @(negedge clk);
    rst = 0; ce = 0;
    repeat (4) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
